// File: rtl/ks_string_engine.sv
// Karplus-Strong string engine: loads a noise burst into a delay line, then replays it through a two-tap averager.
// Output sample lands 2 clocks after the divider terminal tick; no backpressure, CPU strobes are edge-detected.
module ks_string_engine #(
    parameter int DATA_W  = 16,
    parameter int LEN_W   = 10,
    parameter int MAX_LEN = 1024,
    parameter int DIV_W   = 32
) (
    input  logic                     clk_clk,
    input  logic                     reset_reset_n,
    input  logic                     noise_en,
    input  logic                     noise_pulse,
    input  logic signed [DATA_W-1:0] noise_data,
    input  logic [LEN_W-1:0]         sel_nota,
    input  logic [DIV_W-1:0]         div_freq,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic                     load_done,
    output logic                     playing
);

    localparam int ADDR_W = $clog2(MAX_LEN);
    localparam int L_W    = ADDR_W + 1;
    localparam int CMP_W  = (LEN_W > L_W) ? LEN_W : L_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY_WAIT,
        PLAY_RD,
        PLAY_WR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic signed [DATA_W-1:0] r_mem [MAX_LEN];

    logic                     r_pulse_q;
    logic [L_W-1:0]           r_len;
    logic [L_W-1:0]           r_plen;
    logic [L_W-1:0]           r_wr_ptr;
    logic [ADDR_W-1:0]        r_rd_ptr;
    logic signed [DATA_W-1:0] r_prev;
    logic [DIV_W-1:0]         r_tick;
    logic signed [DATA_W-1:0] r_sample_out;
    logic                     r_sample_valid;
    logic                     r_load_done;
    logic                     r_playing;

    logic                     w_rise;
    logic [CMP_W-1:0]         w_sel;
    logic [L_W-1:0]           w_len_clamp;
    logic [DIV_W-1:0]         w_div_eff;
    logic                     w_tick_done;
    logic                     w_ld_entry;
    logic                     w_ld_write;
    logic                     w_play_start;
    logic                     w_tick_en;
    logic                     w_rd_fire;
    logic                     w_wr_fire;
    logic signed [DATA_W:0]   w_sum;
    logic signed [DATA_W-1:0] w_y;
    logic                     w_mem_we;
    logic [ADDR_W-1:0]        w_mem_addr;
    logic signed [DATA_W-1:0] w_mem_wdat;

    assign w_rise = noise_pulse & ~r_pulse_q;

    always_comb begin
        w_sel       = CMP_W'(sel_nota);
        w_len_clamp = L_W'(w_sel);
        if (w_sel < CMP_W'(2)) begin
            w_len_clamp = L_W'(2);
        end else if (w_sel > CMP_W'(MAX_LEN)) begin
            w_len_clamp = L_W'(MAX_LEN);
        end
    end

    // Divider values below 2 behave as 2 so the output period never drops under 4 clocks.
    assign w_div_eff   = (div_freq < DIV_W'(2)) ? DIV_W'(2) : div_freq;
    assign w_tick_done = (r_tick >= w_div_eff - DIV_W'(1));

    assign w_sum = $signed({r_sample_out[DATA_W-1], r_sample_out})
                 + $signed({r_prev[DATA_W-1], r_prev});
    assign w_y   = DATA_W'(w_sum >>> 1);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_ld_entry   = 1'b0;
        w_ld_write   = 1'b0;
        w_play_start = 1'b0;
        w_tick_en    = 1'b0;
        w_rd_fire    = 1'b0;
        w_wr_fire    = 1'b0;
        case (r_state)
            IDLE: begin
                if (noise_en) begin
                    w_next     = LOAD;
                    w_ld_entry = 1'b1;
                end
            end
            LOAD: begin
                if (noise_en) begin
                    w_ld_write = w_rise && (r_wr_ptr < r_len);
                end else if (r_wr_ptr < L_W'(2)) begin
                    w_next = IDLE;
                end else begin
                    w_next       = PLAY_WAIT;
                    w_play_start = 1'b1;
                end
            end
            PLAY_WAIT, PLAY_RD, PLAY_WR: begin
                if (noise_en) begin
                    w_next     = LOAD;
                    w_ld_entry = 1'b1;
                end else if (r_state == PLAY_WAIT) begin
                    w_tick_en = 1'b1;
                    if (w_tick_done) begin
                        w_next = PLAY_RD;
                    end
                end else if (r_state == PLAY_RD) begin
                    w_next    = PLAY_WR;
                    w_rd_fire = 1'b1;
                end else begin
                    w_next    = PLAY_WAIT;
                    w_wr_fire = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // One write port shared between the CPU load and the filter writeback.
    assign w_mem_we   = w_ld_write | w_wr_fire;
    assign w_mem_addr = w_ld_write ? r_wr_ptr[ADDR_W-1:0] : r_rd_ptr;
    assign w_mem_wdat = w_ld_write ? noise_data : w_y;

    always_ff @(posedge clk_clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdat;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_pulse_q      <= 1'b0;
            r_len          <= L_W'(2);
            r_plen         <= L_W'(2);
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_prev         <= '0;
            r_tick         <= '0;
            r_sample_out   <= '0;
            r_sample_valid <= 1'b0;
            r_load_done    <= 1'b0;
            r_playing      <= 1'b0;
        end else begin
            r_pulse_q      <= noise_pulse;
            r_sample_valid <= w_rd_fire;
            r_playing      <= (w_next == PLAY_WAIT) || (w_next == PLAY_RD) || (w_next == PLAY_WR);
            if (w_ld_entry) begin
                r_len       <= w_len_clamp;
                r_wr_ptr    <= '0;
                r_load_done <= 1'b0;
            end
            if (w_ld_write) begin
                r_wr_ptr <= r_wr_ptr + L_W'(1);
                if (r_wr_ptr + L_W'(1) == r_len) begin
                    r_load_done <= 1'b1;
                end
            end
            if (w_play_start) begin
                r_plen   <= r_wr_ptr;
                r_rd_ptr <= '0;
                r_prev   <= '0;
                r_tick   <= '0;
            end
            if (w_tick_en) begin
                r_tick <= w_tick_done ? '0 : r_tick + DIV_W'(1);
            end
            // The read register doubles as the output register so sample_out and sample_valid align.
            if (w_rd_fire) begin
                r_sample_out <= r_mem[r_rd_ptr];
            end
            if (w_wr_fire) begin
                r_prev   <= r_sample_out;
                r_rd_ptr <= (L_W'(r_rd_ptr) == r_plen - L_W'(1)) ? '0 : r_rd_ptr + ADDR_W'(1);
            end
        end
    end

    assign sample_out   = r_sample_out;
    assign sample_valid = r_sample_valid;
    assign load_done    = r_load_done;
    assign playing      = r_playing;

endmodule

// File: tb/tb_ks_string_engine.sv
// Scoreboard bench for ks_string_engine: expected samples come from a software Karplus-Strong model.
module tb_ks_string_engine;

    logic               clk;
    logic               rst_n;
    logic               noise_en;
    logic               noise_pulse;
    logic signed [15:0] noise_data;
    logic [9:0]         sel_nota;
    logic [31:0]        div_freq;
    logic signed [15:0] sample_out;
    logic               sample_valid;
    logic               load_done;
    logic               playing;

    ks_string_engine dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .noise_en      (noise_en),
        .noise_pulse   (noise_pulse),
        .noise_data    (noise_data),
        .sel_nota      (sel_nota),
        .div_freq      (div_freq),
        .sample_out    (sample_out),
        .sample_valid  (sample_valid),
        .load_done     (load_done),
        .playing       (playing)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int exp_q[$];
    int exp_period = 0;
    int last_vld   = -1;
    int mdl[1024];
    int mdl_len = 0;
    int mdl_cap = 0;
    int mon_e;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && sample_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample", int'(sample_out), mon_e);
            end
            if (last_vld >= 0) chk("period", cyc - last_vld, exp_period);
            last_vld = cyc;
        end
    end

    // Enter LOAD with length model clamp(sel,2..1024).
    task automatic enter_load(input int sel);
        sel_nota = 10'(sel);
        noise_en = 1'b1;
        mdl_len  = 0;
        mdl_cap  = (sel < 2) ? 2 : sel;
        @(negedge clk);
    endtask

    task automatic pulse(input int d);
        noise_data  = 16'(d);
        noise_pulse = 1'b1;
        @(negedge clk);
        noise_pulse = 1'b0;
        @(negedge clk);
        if (mdl_len < mdl_cap) begin
            mdl[mdl_len] = d;
            mdl_len++;
        end
    endtask

    // Push the next n outputs of a fresh playback run (rd_ptr=0, prev=0).
    task automatic sb_push(input int n);
        int prev;
        int idx;
        int x;
        prev = 0;
        idx  = 0;
        for (int i = 0; i < n; i++) begin
            x = mdl[idx];
            exp_q.push_back(x);
            mdl[idx] = (x + prev) >>> 1;
            prev = x;
            idx = (idx == mdl_len - 1) ? 0 : idx + 1;
        end
    endtask

    task automatic start_play(input int div, input int period);
        div_freq   = div;
        exp_period = period;
        last_vld   = -1;
        noise_en   = 1'b0;
        @(negedge clk);
        chk("playing_on", int'(playing), 1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("drain_left", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic abort_play();
        noise_en = 1'b1;
        @(negedge clk);
        chk("abort_playing", int'(playing), 0);
    endtask

    initial begin
        int saw_play;
        rst_n       = 1'b0;
        noise_en    = 1'b0;
        noise_pulse = 1'b0;
        noise_data  = '0;
        sel_nota    = '0;
        div_freq    = 32'd10;
        repeat (3) @(negedge clk);
        chk("rst_sample_out", int'(sample_out), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_load_done", int'(load_done), 0);
        chk("rst_playing", int'(playing), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic pluck: two laps with filtered writeback, period 12.
        enter_load(4);
        pulse(1000); pulse(-1000); pulse(2000); pulse(0);
        chk("t2_load_done", int'(load_done), 1);
        sb_push(8);
        start_play(10, 12);
        drain(200);
        abort_play();

        // Overflow pulses ignored; div_freq=0 behaves as 2.
        enter_load(4);
        pulse(11); pulse(22); pulse(33);
        chk("t3_load_done_early", int'(load_done), 0);
        pulse(44);
        chk("t3_load_done", int'(load_done), 1);
        pulse(55); pulse(66);
        sb_push(6);
        start_play(0, 4);
        drain(100);
        abort_play();

        // Abort during play with L=3, reload, restart from the top; div_freq=2 then 1.
        enter_load(3);
        pulse(300); pulse(-600); pulse(900);
        sb_push(2);
        start_play(2, 4);
        drain(100);
        abort_play();
        mdl_len = 0;
        pulse(7); pulse(-8); pulse(100);
        chk("t6_load_done", int'(load_done), 1);
        sb_push(6);
        start_play(1, 4);
        drain(100);
        abort_play();

        // A single loaded sample falls back to IDLE without playing.
        noise_en = 1'b0;
        repeat (2) @(negedge clk);
        enter_load(4);
        pulse(1234);
        chk("t4_load_done", int'(load_done), 0);
        noise_en = 1'b0;
        saw_play = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (playing) saw_play = 1;
        end
        chk("t4_no_play", saw_play, 0);

        // Reset in the middle of playback.
        enter_load(2);
        pulse(1234); pulse(77);
        sb_push(1);
        start_play(3, 5);
        drain(100);
        repeat (2) @(negedge clk);
        chk("t1_pre_sample", int'(sample_out), 1234);
        chk("t1_pre_playing", int'(playing), 1);
        rst_n = 1'b0;
        #1;
        chk("t1_rst_sample", int'(sample_out), 0);
        chk("t1_rst_playing", int'(playing), 0);
        chk("t1_rst_valid", int'(sample_valid), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_play = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (playing) saw_play = 1;
        end
        chk("t1_stays_idle", saw_play, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
